// File: rtl/modport_fifo_pkg.sv
// Shared defaults, status flag bundle and occupancy decode for modport_fifo.
// Latency: none (types, constants and a pure function only).
// Backpressure: none (no datapath in this file).
package modport_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int PTR_W      = $clog2(DEPTH_DEF);

    // All occupancy-derived status bits travel together.
    typedef struct packed {
        logic full;
        logic empty;
        logic alm_full;
        logic alm_empty;
    } fifo_stat_t;

    // Turns an occupancy value into the four status flags.
    function automatic fifo_stat_t decode_stat(
        input int occ,
        input int depth,
        input int afull_lvl,
        input int aempty_lvl
    );
        fifo_stat_t s;
        s.full      = (occ == depth);
        s.empty     = (occ == 0);
        s.alm_full  = (occ >= afull_lvl);
        s.alm_empty = (occ <= aempty_lvl);
        return s;
    endfunction

endpackage

// File: rtl/modport_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge; read data follows rd_addr with no clock.
// Backpressure: none; the caller decides when a write is legal.
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO with full/empty and programmable almost-full/almost-empty flags.
// Latency: read data registered, valid one edge after an accepted read; flags follow the registered count.
// Backpressure: writes while full (without a read) and reads while empty are silently dropped.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_wren,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem_rd_dat;
    logic              wr_acc;
    logic              rd_acc;
    fifo_stat_t        stat;

    // When full, a simultaneous read frees the slot the write fills.
    // When empty, there is no bypass: the read is simply ignored.
    assign rd_acc = i_rden & ~o_empty;
    assign wr_acc = i_wren & (~o_full | i_rden);

    modport_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_dat  (i_wrdata),
        .rd_addr (rd_ptr),
        .rd_dat  (mem_rd_dat)
    );

    // Pointer advance; both wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    // Occupancy: +1 on write-only, -1 on read-only, unchanged on both or neither.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered read data; holds its value when no read is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rddata <= '0;
        end else if (rd_acc) begin
            o_rddata <= mem_rd_dat;
        end
    end

    // Flags decoded from the registered count only, so they lag the transfer by one edge.
    always_comb begin
        stat = decode_stat(int'(count), DEPTH, AFULL_LVL, AEMPTY_LVL);
    end

    assign o_full      = stat.full;
    assign o_empty     = stat.empty;
    assign o_alm_full  = stat.alm_full;
    assign o_alm_empty = stat.alm_empty;

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: reset, ordering, fill/overflow, underflow, simultaneous, wrap, mid-op reset.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next one.
// Backpressure: bench models drop rules (full w/o read, empty read) in its reference queue.
module tb_modport_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] i_wrdata;
    logic       i_wren;
    logic       i_rden;
    logic [7:0] o_rddata;
    logic       o_full;
    logic       o_empty;
    logic       o_alm_full;
    logic       o_alm_empty;

    int n_chk;
    int n_fail;
    logic [7:0] ref_q [$];
    logic [7:0] exp_dat;

    modport_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .i_wrdata    (i_wrdata),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .o_rddata    (o_rddata),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_alm_full  (o_alm_full),
        .o_alm_empty (o_alm_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given requests; returns 1ns after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] dat);
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = dat;
        @(posedge clk);
        #1;
        i_wren = 1'b0;
        i_rden = 1'b0;
    endtask

    // Cycle plus reference-queue update and read-data check.
    task automatic mcycle(input string tag, input logic wr, input logic rd, input logic [7:0] dat);
        logic rd_ok;
        logic wr_ok;
        rd_ok = rd && (ref_q.size() > 0);
        wr_ok = wr && ((ref_q.size() < 16) || rd);
        cycle(wr, rd, dat);
        if (rd_ok) begin
            exp_dat = ref_q.pop_front();
            chk(tag, {24'd0, o_rddata}, {24'd0, exp_dat});
        end
        if (wr_ok) ref_q.push_back(dat);
    endtask

    task automatic chk_flags(input string tag, input logic full, input logic empty,
                             input logic afull, input logic aempty);
        chk(tag, {28'd0, o_full, o_empty, o_alm_full, o_alm_empty},
                 {28'd0, full, empty, afull, aempty});
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b0;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_flags("reset_flags", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_rddata", {24'd0, o_rddata}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Order
        cycle(1'b1, 1'b0, 8'h11);
        chk_flags("order_after_w1", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b1, 1'b0, 8'h33);
        cycle(1'b0, 1'b1, 8'h00);
        chk("order_rd0", {24'd0, o_rddata}, 32'h11);
        cycle(1'b0, 1'b1, 8'h00);
        chk("order_rd1", {24'd0, o_rddata}, 32'h22);
        cycle(1'b0, 1'b1, 8'h00);
        chk("order_rd2", {24'd0, o_rddata}, 32'h33);
        chk_flags("order_empty", 1'b0, 1'b1, 1'b0, 1'b1);

        // Underflow
        cycle(1'b0, 1'b1, 8'h00);
        chk("uflow_hold", {24'd0, o_rddata}, 32'h33);
        chk_flags("uflow_flags", 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h00);
        chk("uflow_hold2", {24'd0, o_rddata}, 32'h33);
        cycle(1'b1, 1'b0, 8'h44);
        chk_flags("uflow_one", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h00);
        chk("uflow_rd", {24'd0, o_rddata}, 32'h44);
        chk_flags("uflow_count0", 1'b0, 1'b1, 1'b0, 1'b1);

        // Fill to 16, then a dropped 17th write
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 8'hA0 + 8'(i));
            chk_flags($sformatf("fill_w%0d", i), (i == 16), 1'b0, (i >= 12), (i <= 4));
        end
        cycle(1'b1, 1'b0, 8'hFF);
        chk_flags("fill_drop17", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk($sformatf("fill_rd%0d", i), {24'd0, o_rddata}, {24'd0, 8'hA0 + 8'(i)});
        end
        chk_flags("fill_drained", 1'b0, 1'b1, 1'b0, 1'b1);

        // Simultaneous with 5 entries
        ref_q.delete();
        for (int i = 0; i < 5; i++) mcycle("sim_pre", 1'b1, 1'b0, 8'h50 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            mcycle($sformatf("sim_rw%0d", i), 1'b1, 1'b1, 8'h60 + 8'(i));
            chk_flags($sformatf("sim_cnt5_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) mcycle($sformatf("sim_drain%0d", i), 1'b0, 1'b1, 8'h00);
        chk_flags("sim_empty", 1'b0, 1'b1, 1'b0, 1'b1);

        // Simultaneous when full
        for (int i = 0; i < 16; i++) mcycle("full_pre", 1'b1, 1'b0, 8'hC0 + 8'(i));
        mcycle("full_rw", 1'b1, 1'b1, 8'hD0);
        chk_flags("full_rw_flags", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) mcycle($sformatf("full_drain%0d", i), 1'b0, 1'b1, 8'h00);
        chk_flags("full_empty", 1'b0, 1'b1, 1'b0, 1'b1);

        // Wrap: 40 writes, reading alongside once three words are buffered
        for (int i = 0; i < 40; i++) begin
            mcycle($sformatf("wrap_%0d", i), 1'b1, (ref_q.size() >= 3), 8'(i * 7 + 3));
        end
        while (ref_q.size() > 0) mcycle("wrap_drain", 1'b0, 1'b1, 8'h00);
        chk_flags("wrap_empty", 1'b0, 1'b1, 1'b0, 1'b1);

        // Mid-operation reset with 8 entries
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'h70 + 8'(i));
        cycle(1'b0, 1'b1, 8'h00);
        chk("mrst_pre_rd", {24'd0, o_rddata}, 32'h70);
        chk_flags("mrst_pre_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_flags("mrst_flags", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("mrst_rddata", {24'd0, o_rddata}, 32'h0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h5A);
        chk_flags("mrst_one", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h00);
        chk("mrst_new_word", {24'd0, o_rddata}, 32'h5A);
        chk_flags("mrst_end", 1'b0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
